// File: rtl/sdram_frame_writer.sv
// Avalon-MM burst write master: buffers one frame of Avalon-ST words in a show-ahead
// FIFO and writes it to SDRAM in full bursts, so write never drops inside a burst.
module sdram_frame_writer #(
    parameter int unsigned DATA_WIDTH  = 256,
    parameter int unsigned ADDR_WIDTH  = 27,
    parameter int unsigned BURST_LEN   = 8,
    parameter int unsigned FIFO_DEPTH  = 32,
    parameter int unsigned FRAME_WORDS = 259200
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start_i,
    input  logic [ADDR_WIDTH-1:0]     base_addr_i,
    input  logic [DATA_WIDTH-1:0]     st_data_i,
    input  logic                      st_valid_i,
    output logic                      st_ready_o,
    output logic [ADDR_WIDTH-1:0]     sdram_address_o,
    output logic [7:0]                sdram_burstcount_o,
    input  logic                      sdram_waitrequest_i,
    output logic [DATA_WIDTH-1:0]     sdram_writedata_o,
    output logic [DATA_WIDTH/8-1:0]   sdram_byteenable_o,
    output logic                      sdram_write_o,
    output logic                      busy_o,
    output logic                      frame_done_o
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned REM_W = ($clog2(FRAME_WORDS + 1) > 8) ? $clog2(FRAME_WORDS + 1) : 8;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FILL,
        S_BURST
    } state_t;

    state_t                r_state, w_state_nxt;
    logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      r_wr_ptr, r_rd_ptr;
    logic [CNT_W-1:0]      r_count, w_count_nxt;
    logic [ADDR_WIDTH-1:0] r_ptr, w_ptr_nxt;
    logic [ADDR_WIDTH-1:0] r_addr, w_addr_nxt;
    logic [REM_W-1:0]      r_wr_rem, w_wr_rem_nxt;
    logic [REM_W-1:0]      r_in_rem, w_in_rem_nxt;
    logic [7:0]            r_bc, w_bc_nxt;
    logic [7:0]            r_beats, w_beats_nxt;
    logic [7:0]            w_bc;
    logic                  r_write, w_write_nxt;
    logic                  r_busy, w_busy_nxt;
    logic                  r_done, w_done_nxt;
    logic                  r_ready, w_ready_nxt;
    logic                  w_push, w_pop;

    assign w_push      = st_valid_i && r_ready;
    assign w_pop       = r_write && !sdram_waitrequest_i;
    assign w_count_nxt = r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    assign w_bc        = (r_wr_rem < REM_W'(BURST_LEN)) ? 8'(r_wr_rem) : 8'(BURST_LEN);

    assign st_ready_o         = r_ready;
    assign sdram_address_o    = r_addr;
    assign sdram_burstcount_o = r_bc;
    assign sdram_writedata_o  = r_mem[r_rd_ptr];
    assign sdram_byteenable_o = '1;
    assign sdram_write_o      = r_write;
    assign busy_o             = r_busy;
    assign frame_done_o       = r_done;

    // FIFO storage carries no reset; only pointers and count are cleared.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= st_data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ptr    <= '0;
            r_addr   <= '0;
            r_wr_rem <= '0;
            r_in_rem <= '0;
            r_bc     <= '0;
            r_beats  <= '0;
            r_write  <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_ready  <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_wr_ptr <= w_push ? r_wr_ptr + PTR_W'(1) : r_wr_ptr;
            r_rd_ptr <= w_pop ? r_rd_ptr + PTR_W'(1) : r_rd_ptr;
            r_count  <= w_count_nxt;
            r_ptr    <= w_ptr_nxt;
            r_addr   <= w_addr_nxt;
            r_wr_rem <= w_wr_rem_nxt;
            r_in_rem <= w_in_rem_nxt;
            r_bc     <= w_bc_nxt;
            r_beats  <= w_beats_nxt;
            r_write  <= w_write_nxt;
            r_busy   <= w_busy_nxt;
            r_done   <= w_done_nxt;
            r_ready  <= w_ready_nxt;
        end
    end

    // Next state; a burst is launched only once all of its beats sit in the FIFO.
    always_comb begin
        w_state_nxt  = r_state;
        w_ptr_nxt    = r_ptr;
        w_addr_nxt   = r_addr;
        w_wr_rem_nxt = r_wr_rem;
        w_in_rem_nxt = w_push ? r_in_rem - REM_W'(1) : r_in_rem;
        w_bc_nxt     = r_bc;
        w_beats_nxt  = r_beats;
        w_write_nxt  = r_write;
        w_busy_nxt   = r_busy;
        w_done_nxt   = 1'b0;
        w_ready_nxt  = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (start_i) begin
                    w_ptr_nxt    = base_addr_i;
                    w_wr_rem_nxt = REM_W'(FRAME_WORDS);
                    w_in_rem_nxt = REM_W'(FRAME_WORDS);
                    w_busy_nxt   = 1'b1;
                    w_state_nxt  = S_FILL;
                end
            end
            S_FILL: begin
                if (32'(r_count) >= 32'(w_bc)) begin
                    w_addr_nxt  = r_ptr;
                    w_bc_nxt    = w_bc;
                    w_beats_nxt = w_bc;
                    w_write_nxt = 1'b1;
                    w_state_nxt = S_BURST;
                end
            end
            S_BURST: begin
                if (w_pop) begin
                    w_beats_nxt = r_beats - 8'd1;
                    if (r_beats == 8'd1) begin
                        w_ptr_nxt    = r_ptr + ADDR_WIDTH'(r_bc);
                        w_wr_rem_nxt = r_wr_rem - REM_W'(r_bc);
                        w_write_nxt  = 1'b0;
                        if (r_wr_rem == REM_W'(r_bc)) begin
                            w_done_nxt  = 1'b1;
                            w_busy_nxt  = 1'b0;
                            w_state_nxt = S_IDLE;
                        end else begin
                            w_state_nxt = S_FILL;
                        end
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase

        w_ready_nxt = (w_state_nxt != S_IDLE) && (w_count_nxt != CNT_W'(FIFO_DEPTH))
                      && (w_in_rem_nxt != '0);
    end

endmodule
